result_deskew: RTL and testbench

RESULT_DESKEW -- requirements
Module: result_deskew

---
 rtl/systolic_pkg.sv | 16 +
 rtl/row_fifo.sv | 69 ++++++
 rtl/result_deskew.sv | 160 ++++++++++++++++
 tb/tb_result_deskew.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array result path.
package systolic_pkg;

  localparam int unsigned DefMatrixSize = 2;
  localparam int unsigned DefDataSize   = 32;
  localparam int unsigned DefFifoDepth  = 4;

  typedef logic [DefDataSize-1:0] psum_t;

  typedef enum logic [1:0] {
    SliceEmpty,
    SliceComplete,
    SliceMixed
  } slice_e;

endpackage

// File: rtl/row_fifo.sv
// Synchronous FIFO of whole result rows; a push into a full FIFO succeeds only alongside a pop.
module row_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointers wrap naturally
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/result_deskew.sv
// Realigns skewed column outputs of a systolic array into whole rows and buffers them
// for a ready/valid consumer.
module result_deskew
  import systolic_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE = DefMatrixSize,
  parameter int unsigned DATA_SIZE   = DefDataSize,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   general_enable,
  input  logic [MATRIX_SIZE-1:0] in_valid,
  input  logic [DATA_SIZE-1:0]   in_psum [MATRIX_SIZE],
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_SIZE-1:0]   out_row [MATRIX_SIZE],
  output logic                   done,
  output logic                   overflow,
  output logic                   skew_err
);

  localparam int unsigned RowW = MATRIX_SIZE * DATA_SIZE;
  localparam int unsigned CntW = $clog2(MATRIX_SIZE + 1);
  localparam logic [CntW-1:0] RowsTotal = CntW'(MATRIX_SIZE);

  logic [MATRIX_SIZE-1:0] aligned_valid;
  logic [DATA_SIZE-1:0]   aligned_psum [MATRIX_SIZE];
  slice_e                 slice_kind;

  logic            fifo_full, fifo_empty;
  logic [RowW-1:0] fifo_wdata, fifo_rdata;
  logic            push, pop, drop;

  logic [CntW-1:0] row_cnt_q, row_cnt_d;
  logic            done_q, done_d;
  logic            overflow_q, overflow_d;
  logic            skew_err_q, skew_err_d;

  // Column j waits N-1-j cycles so that all columns of a row line up with column N-1.
  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int Dly = int'(MATRIX_SIZE) - 1 - j;
    if (Dly == 0) begin : g_pass
      assign aligned_valid[j] = in_valid[j];
      assign aligned_psum[j]  = in_psum[j];
    end else begin : g_dly
      logic [Dly-1:0]       vld_q, vld_d;
      logic [DATA_SIZE-1:0] dat_q [Dly];
      logic [DATA_SIZE-1:0] dat_d [Dly];

      always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (general_enable) begin
          vld_d[0] = in_valid[j];
          dat_d[0] = in_psum[j];
          for (int k = 1; k < Dly; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = dat_q[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= '0;
          for (int k = 0; k < Dly; k++) begin
            dat_q[k] <= '0;
          end
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end

      assign aligned_valid[j] = vld_q[Dly-1];
      assign aligned_psum[j]  = dat_q[Dly-1];
    end
  end

  always_comb begin
    if (&aligned_valid) begin
      slice_kind = SliceComplete;
    end else if (|aligned_valid) begin
      slice_kind = SliceMixed;
    end else begin
      slice_kind = SliceEmpty;
    end
  end

  always_comb begin
    fifo_wdata = '0;
    for (int j = 0; j < int'(MATRIX_SIZE); j++) begin
      fifo_wdata[j*DATA_SIZE +: DATA_SIZE] = aligned_psum[j];
    end
  end

  assign out_valid = general_enable && !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = general_enable && (slice_kind == SliceComplete) && (!fifo_full || pop);
  assign drop      = general_enable && (slice_kind == SliceComplete) && fifo_full && !pop;

  row_fifo #(
    .Width (RowW),
    .Depth (FIFO_DEPTH)
  ) u_row_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head row is held while stalled; zero when nothing is buffered.
  always_comb begin
    for (int j = 0; j < int'(MATRIX_SIZE); j++) begin
      out_row[j] = fifo_empty ? '0 : fifo_rdata[j*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_comb begin
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q;
    skew_err_d = skew_err_q;
    if (general_enable) begin
      if (pop && (row_cnt_q != RowsTotal)) begin
        row_cnt_d = row_cnt_q + CntW'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
      if (slice_kind == SliceMixed) begin
        skew_err_d = 1'b1;
      end
    end
    done_d = (row_cnt_d == RowsTotal);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt_q  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      skew_err_q <= 1'b0;
    end else begin
      row_cnt_q  <= row_cnt_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      skew_err_q <= skew_err_d;
    end
  end

  assign done     = done_q;
  assign overflow = overflow_q;
  assign skew_err = skew_err_q;

endmodule

// File: tb/tb_result_deskew.sv
// Bench for result_deskew: directed scenarios plus a randomized run against a queue model.
module tb_result_deskew;

  localparam int N    = 2;
  localparam int W    = 32;
  localparam int D    = 4;
  localparam int RCYC = 400;

  logic         clk = 1'b0;
  logic         reset;
  logic         general_enable;
  logic [N-1:0] in_valid;
  logic [W-1:0] in_psum [N];
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_row [N];
  logic         done;
  logic         overflow;
  logic         skew_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic             hv [RCYC][N];
  logic [W-1:0]     hd [RCYC][N];
  logic [N*W-1:0]   mq [$];

  result_deskew #(
    .MATRIX_SIZE (N),
    .DATA_SIZE   (W),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .general_enable (general_enable),
    .in_valid       (in_valid),
    .in_psum        (in_psum),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_row        (out_row),
    .done           (done),
    .overflow       (overflow),
    .skew_err       (skew_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [W-1:0] d0,
                       input logic [W-1:0] d1);
    in_valid   = {v1, v0};
    in_psum[0] = d0;
    in_psum[1] = d1;
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    general_enable = 1'b1;
    out_ready      = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    general_enable = 1'b1;
    out_ready      = 1'b1;
    drive(1'b1, 1'b1, 32'hdead_beef, 32'hcafe_f00d);
    step();
    step();
    step();
    tests_run++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid_done: valid=%b done=%b want 0 0", out_valid, done);
    end
    tests_run++;
    if (overflow !== 1'b0 || skew_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: overflow=%b skew_err=%b want 0 0", overflow, skew_err);
    end
    tests_run++;
    if (out_row[0] !== '0 || out_row[1] !== '0) begin
      tests_failed++;
      $display("FAIL reset_row: row=%h,%h want 0,0", out_row[0], out_row[1]);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h11, '0);
    step();
    drive(1'b0, 1'b1, '0, 32'h22);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_early: out_valid=%b want 0", out_valid);
    end
    step();
    drive(1'b0, 1'b0, '0, '0);
    tests_run++;
    if (out_valid !== 1'b1 || out_row[0] !== 32'h11 || out_row[1] !== 32'h22) begin
      tests_failed++;
      $display("FAIL basic_row: valid=%b row=%h,%h want 1 11,22", out_valid, out_row[0],
               out_row[1]);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pulse: valid=%b done=%b want 0 0", out_valid, done);
    end
  endtask

  task automatic test_back_to_back_done();
    apply_reset();
    for (int k = 0; k <= 2; k++) begin
      drive(k < 2, k >= 1, 32'(32'h500 + k), 32'(32'h600 + k - 1));
      step();
    end
    drive(1'b0, 1'b0, '0, '0);
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_row[0] !== 32'(32'h500 + r) ||
          out_row[1] !== 32'(32'h600 + r) || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_pop%0d: valid=%b row=%h,%h done=%b want 1 %h,%h 0", r, out_valid,
                 out_row[0], out_row[1], done, 32'h500 + r, 32'h600 + r);
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL done_level%0d: done=%b valid=%b want 1 0", k, done, out_valid);
      end
      step();
    end
    // one more row after done: still legal, done stays high
    drive(1'b1, 1'b0, 32'h777, '0);
    step();
    drive(1'b0, 1'b1, '0, 32'h888);
    step();
    drive(1'b0, 1'b0, '0, '0);
    tests_run++;
    if (out_valid !== 1'b1 || out_row[0] !== 32'h777 || out_row[1] !== 32'h888) begin
      tests_failed++;
      $display("FAIL extra_row: valid=%b row=%h,%h want 1 777,888", out_valid, out_row[0],
               out_row[1]);
    end
    step();
    tests_run++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_saturate: done=%b valid=%b want 1 0", done, out_valid);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int k = 0; k <= 5; k++) begin
      drive(k < 5, k >= 1, 32'(32'h100 + k), 32'(32'h200 + k - 1));
      if (k == 5) begin
        tests_run++;
        if (overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL overflow_early: overflow=%b want 0", overflow);
        end
      end
      step();
    end
    drive(1'b0, 1'b0, '0, '0);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_set: overflow=%b want 1", overflow);
    end
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_row[0] !== 32'(32'h100 + r) ||
          out_row[1] !== 32'(32'h200 + r)) begin
        tests_failed++;
        $display("FAIL overflow_pop%0d: valid=%b row=%h,%h want 1 %h,%h", r, out_valid,
                 out_row[0], out_row[1], 32'h100 + r, 32'h200 + r);
      end
      step();
    end
    tests_run++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_drained: valid=%b overflow=%b want 0 1", out_valid, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int k = 0; k <= 5; k++) begin
      out_ready = (k == 5);
      drive(k < 5, k >= 1, 32'(32'h300 + k), 32'(32'h400 + k - 1));
      if (k == 5) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_row[0] !== 32'h300 || out_row[1] !== 32'h400) begin
          tests_failed++;
          $display("FAIL full_head: valid=%b row=%h,%h want 1 300,400", out_valid, out_row[0],
                   out_row[1]);
        end
      end
      step();
    end
    out_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_no_overflow: overflow=%b want 0", overflow);
    end
    out_ready = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_row[0] !== 32'(32'h300 + r) ||
          out_row[1] !== 32'(32'h400 + r)) begin
        tests_failed++;
        $display("FAIL full_pop%0d: valid=%b row=%h,%h want 1 %h,%h", r, out_valid,
                 out_row[0], out_row[1], 32'h300 + r, 32'h400 + r);
      end
      step();
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_drained: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_skew_err();
    apply_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 32'haa, '0);
    step();
    drive(1'b0, 1'b0, '0, '0);
    tests_run++;
    if (skew_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL skew_early: skew_err=%b want 0", skew_err);
    end
    step();
    tests_run++;
    if (skew_err !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL skew_set: skew_err=%b valid=%b want 1 0", skew_err, out_valid);
    end
    step();
    tests_run++;
    if (skew_err !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL skew_sticky: skew_err=%b valid=%b want 1 0", skew_err, out_valid);
    end
  endtask

  task automatic test_enable();
    apply_reset();
    drive(1'b1, 1'b0, 32'h77, '0);
    step();
    general_enable = 1'b0;
    drive(1'b0, 1'b1, '0, 32'h99);
    step();
    general_enable = 1'b1;
    drive(1'b0, 1'b1, '0, 32'h88);
    step();
    drive(1'b0, 1'b0, '0, '0);
    tests_run++;
    if (out_valid !== 1'b1 || out_row[0] !== 32'h77 || out_row[1] !== 32'h88) begin
      tests_failed++;
      $display("FAIL enable_frozen_row: valid=%b row=%h,%h want 1 77,88", out_valid,
               out_row[0], out_row[1]);
    end
    general_enable = 1'b0;
    out_ready      = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL enable_forces_low: valid=%b want 0", out_valid);
    end
    step();
    general_enable = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_row[0] !== 32'h77 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL enable_no_pop: valid=%b row0=%h done=%b want 1 77 0", out_valid,
               out_row[0], done);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL enable_single_row: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1'b0, 1'b1, '0, 32'h1);
    step();
    drive(1'b1, 1'b0, 32'h900, '0);
    step();
    drive(1'b1, 1'b1, 32'h901, 32'ha00);
    step();
    drive(1'b1, 1'b1, 32'h902, 32'ha01);
    step();
    drive(1'b0, 1'b0, '0, '0);
    tests_run++;
    if (out_valid !== 1'b1 || skew_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_pre: valid=%b skew_err=%b want 1 1", out_valid, skew_err);
    end
    reset          = 1'b1;
    general_enable = 1'b0;
    step();
    reset          = 1'b0;
    general_enable = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || skew_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_clear: valid=%b done=%b ovf=%b skew=%b want 0 0 0 0", out_valid,
               done, overflow, skew_err);
    end
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h55, '0);
    step();
    drive(1'b0, 1'b1, '0, 32'h66);
    tests_run++;
    if (out_valid !== 1'b0 || skew_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_inflight: valid=%b skew=%b want 0 0", out_valid, skew_err);
    end
    step();
    drive(1'b0, 1'b0, '0, '0);
    tests_run++;
    if (out_valid !== 1'b1 || out_row[0] !== 32'h55 || out_row[1] !== 32'h66) begin
      tests_failed++;
      $display("FAIL midreset_new_row: valid=%b row=%h,%h want 1 55,66", out_valid,
               out_row[0], out_row[1]);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_drained: valid=%b want 0", out_valid);
    end
  endtask

  // Model: the aligned slice at cycle c takes column j from input cycle c-(N-1-j).
  task automatic test_random();
    logic           exp_ovf, exp_skew, exp_valid, pop, all_v, any_v, av;
    logic [N*W-1:0] row, obs;
    int             pops, idx;
    apply_reset();
    exp_ovf  = 1'b0;
    exp_skew = 1'b0;
    pops     = 0;
    mq.delete();
    for (int c = 0; c < RCYC; c++) begin
      hv[c][0] = 1'($urandom_range(0, 1));
      hv[c][1] = (c > 0) ? hv[c-1][0] : 1'b0;
      if ($urandom_range(0, 9) == 0) hv[c][1] = ~hv[c][1];
      hd[c][0] = $urandom;
      hd[c][1] = $urandom;
      out_ready = ($urandom_range(0, 9) < 4);
      drive(hv[c][0], hv[c][1], hd[c][0], hd[c][1]);
      #1;
      exp_valid = (mq.size() > 0);
      tests_run++;
      if (out_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL rand_valid c=%0d: got %b want %b", c, out_valid, exp_valid);
      end
      if (exp_valid) begin
        for (int j = 0; j < N; j++) obs[j*W +: W] = out_row[j];
        tests_run++;
        if (obs !== mq[0]) begin
          tests_failed++;
          $display("FAIL rand_row c=%0d: got %h want %h", c, obs, mq[0]);
        end
      end
      tests_run++;
      if (done !== (pops >= N) || overflow !== exp_ovf || skew_err !== exp_skew) begin
        tests_failed++;
        $display("FAIL rand_flags c=%0d: done=%b ovf=%b skew=%b want %b %b %b", c, done,
                 overflow, skew_err, pops >= N, exp_ovf, exp_skew);
      end
      pop   = exp_valid && out_ready;
      all_v = 1'b1;
      any_v = 1'b0;
      for (int j = 0; j < N; j++) begin
        idx = c - (N - 1 - j);
        av  = (idx >= 0) ? hv[idx][j] : 1'b0;
        all_v &= av;
        any_v |= av;
        row[j*W +: W] = (idx >= 0) ? hd[idx][j] : '0;
      end
      if (pop) begin
        void'(mq.pop_front());
        pops++;
      end
      if (all_v) begin
        if (mq.size() < D) mq.push_back(row);
        else exp_ovf = 1'b1;
      end else if (any_v) begin
        exp_skew = 1'b1;
      end
      step();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    general_enable = 1'b1;
    out_ready      = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    test_reset();
    test_basic();
    test_back_to_back_done();
    test_overflow();
    test_full_push_pop();
    test_skew_err();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
